// File: rtl/sensor_node_responder.sv
// sensor_node_responder: node side of the hub<->node sensor link.
// Decodes hub requests, snapshots the addressed sensor and replies with a
// header byte followed by the measurement byte.
module sensor_node_responder #(
   parameter int         CLK_FREQ_HZ        = 25_000_000,
   parameter int         BAUD_RATE          = 9600,
   parameter logic [1:0] NODE_ID            = 2'd0,
   parameter logic [3:0] SENSOR_MASK        = 4'b1111,
   parameter int         REQ_TIMEOUT_CYCLES = (CLK_FREQ_HZ / BAUD_RATE) * 20,
   parameter int         TURNAROUND_CYCLES  = 250
) (
   input  logic        clk_25mhz,
   input  logic        reset_n_internal,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   input  logic        tx_active,
   input  logic        tx_done,
   input  logic [31:0] sensor_data,
   output logic        tx_dv,
   output logic [7:0]  tx_byte,
   output logic        busy,
   output logic [7:0]  req_count,
   output logic [7:0]  err_count
);

   localparam int TMAX = REQ_TIMEOUT_CYCLES > TURNAROUND_CYCLES ? REQ_TIMEOUT_CYCLES : TURNAROUND_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {IDLE, WAIT_ARG, TURNAROUND, SEND_HDR, WAIT_HDR, SEND_VAL, WAIT_VAL} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [1:0]    sala;
   logic [1:0]    sensor;
   logic [7:0]    hdr;
   logic [7:0]    val;
   logic          drop;
   logic          timed_out;
   logic          turned;
   logic [7:0]    sel_byte;
   logic          unused_arg_bits;

   // The two low bits of the request byte carry no meaning on this node.
   assign unused_arg_bits = ^rx_byte[1:0];

   assign busy = state != IDLE;

   // Byte-drop detection, timer terminal counts and the addressed sensor byte.
   always_comb begin
      drop      = rx_dv && (state == IDLE ? rx_byte[7:6] != 2'b10 : state != WAIT_ARG);
      timed_out = timer == TW'(REQ_TIMEOUT_CYCLES - 1);
      turned    = timer == TW'(TURNAROUND_CYCLES - 1);
      sel_byte  = sensor_data[{sensor, 3'b000} +: 8];
   end

   // Request/response sequencer with registered UART strobe and counters.
   always_ff @(posedge clk_25mhz or negedge reset_n_internal) begin
      if (!reset_n_internal) begin
         state     <= IDLE;
         timer     <= '0;
         sala      <= 2'd0;
         sensor    <= 2'd0;
         hdr       <= 8'h00;
         val       <= 8'h00;
         tx_dv     <= 1'b0;
         tx_byte   <= 8'h00;
         req_count <= 8'd0;
         err_count <= 8'd0;
      end else begin
         tx_dv <= 1'b0;
         if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
         case (state)
            IDLE:
               if (rx_dv && rx_byte[7:6] == 2'b10) begin
                  sala   <= rx_byte[5:4];
                  sensor <= rx_byte[3:2];
                  timer  <= '0;
                  state  <= WAIT_ARG;
               end
            WAIT_ARG:
               if (rx_dv || timed_out) begin
                  timer <= '0;
                  hdr   <= {2'b11, sala, sensor, SENSOR_MASK[sensor] ? 2'b00 : 2'b01};
                  val   <= SENSOR_MASK[sensor] ? sel_byte : 8'h00;
                  state <= sala == NODE_ID ? TURNAROUND : IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            TURNAROUND:
               if (turned) state <= SEND_HDR;
               else timer <= timer + TW'(1);
            SEND_HDR:
               if (!tx_active) begin
                  tx_dv   <= 1'b1;
                  tx_byte <= hdr;
                  state   <= WAIT_HDR;
               end
            WAIT_HDR:
               if (tx_done) state <= SEND_VAL;
            SEND_VAL:
               if (!tx_active) begin
                  tx_dv   <= 1'b1;
                  tx_byte <= val;
                  state   <= WAIT_VAL;
               end
            WAIT_VAL:
               if (tx_done) begin
                  req_count <= req_count + 8'd1;
                  state     <= IDLE;
               end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule
